dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Data-memory controller that sits directly downstream of the single-cycle CPU's DMEM port (dm_ena/dm_r/dm_w, dm_addr, dm_data_w and the eight size flags). It drives a word-wide, synchronous-read, single-port SRAM that has no byte enables, and returns sized, extended load data on dm_data. It handles byte/half stores by read-modify-write and stalls the CPU while a multi-cycle access is in flight. The top level gates the CPU's ena with ~stall.

Parameters:
ADDR_W, 11, SRAM word-address width (2^ADDR_W words).
BASE_ADDR, 32'h10010000, byte address that maps to SRAM word 0.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
ena  in  1  global enable (same signal the CPU receives before stall gating)
dm_ena  in  1  CPU access request
dm_r  in  1  CPU read strobe
dm_w  in  1  CPU write strobe
dm_addr  in  32  CPU byte address
dm_data_w  in  32  CPU store data (Rt)
sb_flag, sh_flag, sw_flag  in  1 each  store size, one-hot when dm_w
lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag  in  1 each  load size/sign, one-hot when dm_r
dm_data  out  32  load result to the CPU write-back mux
stall  out  1  CPU must hold its state this cycle
mem_en  out  1  SRAM enable
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_W  SRAM word address
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data, valid one cycle after mem_en && !mem_we
fault  out  1  one-cycle pulse for a rejected access
fault_code  out  2  01 misaligned, 10 out of range; held until the next fault

Behaviour:
- Offset = dm_addr - BASE_ADDR. Word index = offset[ADDR_W+1:2]. Lane = offset[1:0], little-endian: lane 0 is bits [7:0].
- Request is valid when ena && dm_ena && state==IDLE.
- Misaligned access: lw/sw with lane != 0, or lh/lhu/sh with lane[0] != 0.
- Out-of-range access: offset < 0 (borrow) or offset[31:ADDR_W+2] != 0.
- FSM states: IDLE, RD, RMW_RD, RMW_WR, DONE.
  - IDLE with a faulted request: no SRAM access, stall=1, go to DONE with fault latched.
  - IDLE with a valid sw: combinational mem_en=1, mem_we=1, mem_wdata=dm_data_w. stall=0, stay in IDLE (zero wait states).
  - IDLE with a valid load: mem_en=1, mem_we=0, stall=1, go to RD.
  - RD: extract and extend mem_rdata into rdata_q. stall=1, go to DONE.
  - IDLE with a valid sb/sh: issue a read, stall=1, go to RMW_RD.
  - RMW_RD: merge dm_data_w[7:0] or [15:0] into the addressed lane(s) of mem_rdata and register into wbuf. stall=1, go to RMW_WR.
  - RMW_WR: mem_en=1, mem_we=1, mem_wdata=wbuf. stall=1, go to DONE.
  - DONE: stall=0, dm_data=rdata_q. The fault pulse is asserted here. Go to IDLE. The CPU commits on this edge.
- Load extension:
  - lb sign-extends the selected byte; lbu zero-extends it.
  - lh/lhu do the same for the halfword at lane 0 or 2.
  - lw passes the word through.
  - A faulted load returns 0.
- Latency in stall cycles: sw 0, loads 2, sb/sh 3, faulted access 1.
- ena low: FSM holds its state, all mem_* outputs are 0, stall holds its last combinational value.
- mem_addr, mem_wdata, mem_we are 0 whenever mem_en=0.
- Reset (asynchronous, any state): state=IDLE, rdata_q=0, wbuf=0, fault=0, fault_code=0. An interrupted RMW must never issue its write.
- Outputs after reset: dm_data=0, stall=0, mem_*=0.
- Simultaneous dm_r && dm_w is illegal. It is treated as a read; the write is dropped.

Decomposition:
- dmem_pkg holds:
  - state encoding constants;
  - fault codes (FAULT_MISALIGN=2'b01, FAULT_RANGE=2'b10);
  - size encoding (SZ_B, SZ_H, SZ_W) derived from the flags.
- One natural sub-module, dmem_lane: a purely combinational lane extract/extend and lane merge, shared by the RD and RMW_RD paths.

Test Plan:
- SRAM word 0 = 0x8899AABB. lb @0x10010001 -> stall high 2 cycles, dm_data=0xFFFFFFAA. lbu at the same address -> 0x000000AA.
- sw 0x12345678 @0x10010004 -> same-cycle mem_we=1, mem_addr=1, stall=0. Then lh @0x10010006 -> 0x00001234.
- Word 2 = 0xFFFFFFFF. sb 0x5A @0x1001000B -> read, then write of 0x5AFFFFFF to word 2, stall high 3 cycles.
- sh @0x10010003 -> no mem_we, fault pulse in DONE, fault_code=01. lw @0x0FFFFFFC -> fault_code=10, dm_data=0.
- Assert rst during RMW_RD of an sb -> mem_we never asserts, word unchanged, state IDLE, stall=0 immediately.
- Hold ena=0 for 3 cycles while in RD -> state frozen. After ena returns, the load completes with the correct value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Purpose: shared types for the data-memory controller (states, fault codes, access size).
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package dmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_RMW_WR = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    // Collapse the one-hot byte/half flags into a size; anything else is a word.
    function automatic size_t size_of(input logic is_b, input logic is_h);
        if (is_b) begin
            return SZ_B;
        end
        if (is_h) begin
            return SZ_H;
        end
        return SZ_W;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Purpose: CPU-side DMEM request/response plus SRAM-side port, bundled for dmem_ctrl.
// Latency: n/a (wiring only).
// Backpressure: stall from the controller holds the CPU; the SRAM never back-pressures.
// Ports: master = CPU + SRAM environment, slave = controller.
interface dmem_ctrl_if #(
    parameter int ADDR_W = 11
);
    logic              ena;
    logic              dm_ena;
    logic              dm_r;
    logic              dm_w;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_data_w;
    logic              sb_flag;
    logic              sh_flag;
    logic              sw_flag;
    logic              lb_flag;
    logic              lh_flag;
    logic              lbu_flag;
    logic              lhu_flag;
    logic              lw_flag;
    logic [31:0]       dm_data;
    logic              stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              fault;
    logic [1:0]        fault_code;

    modport master (
        output ena, dm_ena, dm_r, dm_w, dm_addr, dm_data_w,
               sb_flag, sh_flag, sw_flag, lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag,
               mem_rdata,
        input  dm_data, stall, mem_en, mem_we, mem_addr, mem_wdata, fault, fault_code
    );

    modport slave (
        input  ena, dm_ena, dm_r, dm_w, dm_addr, dm_data_w,
               sb_flag, sh_flag, sw_flag, lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag,
               mem_rdata,
        output dm_data, stall, mem_en, mem_we, mem_addr, mem_wdata, fault, fault_code
    );
endinterface

// File: rtl/dmem_lane.sv
// Purpose: lane extract/extend for loads and lane merge for sub-word stores.
// Latency: combinational.
// Backpressure: none.
// Ports: word (SRAM word), lane, size, sign -> ld_data; st_data merged into word -> merged.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  size_t       size,
    input  logic        sign,
    input  logic [15:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] merged
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];

        ld_data = word;
        merged  = word;
        case (size)
            SZ_B: begin
                ld_data = sign ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
                merged[{lane, 3'b000} +: 8] = st_data[7:0];
            end
            SZ_H: begin
                ld_data = sign ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
                if (lane[1]) begin
                    merged[31:16] = st_data;
                end else begin
                    merged[15:0] = st_data;
                end
            end
            default: begin
                ld_data = word;
                merged  = word;
            end
        endcase
    end
endmodule

// File: rtl/dmem_ctrl.sv
// Purpose: CPU DMEM port to word-wide sync SRAM; sized loads, read-modify-write sub-word stores.
// Latency: sw 0 stall cycles, loads 2, sb/sh 3, rejected access 1.
// Backpressure: stall holds the CPU; ena low freezes the FSM and silences the SRAM port.
// Ports: clk, rst (async, active high), bus (slave modport of dmem_ctrl_if).
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          ADDR_W    = 11,
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
    input logic        clk,
    input logic        rst,
    dmem_ctrl_if.slave bus
);
    state_t            state, next_state;
    logic [31:0]       rdata_q, wbuf;
    logic              flt_pend, stall_q;
    logic [1:0]        fault_code_q;

    logic [32:0]       diff;
    logic [31:0]       offset;
    logic [1:0]        lane;
    logic              is_rd, is_wr, sign, misalign, range_err, req, flt;
    size_t             size;
    logic [31:0]       ld_data, merged;

    logic              stall_c, m_en, m_we;
    logic [31:0]       m_wdata;

    // Borrow out of the 33-bit subtract flags addresses below the window.
    assign diff   = {1'b0, bus.dm_addr} - {1'b0, BASE_ADDR};
    assign offset = diff[31:0];
    assign lane   = offset[1:0];

    // A read strobe wins over a simultaneous write; a strobe without any size flag is ignored.
    assign is_rd = bus.dm_r && (bus.lb_flag || bus.lbu_flag || bus.lh_flag || bus.lhu_flag || bus.lw_flag);
    assign is_wr = bus.dm_w && !bus.dm_r && (bus.sb_flag || bus.sh_flag || bus.sw_flag);
    assign size  = bus.dm_r ? size_of(bus.lb_flag || bus.lbu_flag, bus.lh_flag || bus.lhu_flag)
                            : size_of(bus.sb_flag, bus.sh_flag);
    assign sign  = bus.lb_flag || bus.lh_flag;

    assign misalign  = ((size == SZ_W) && (lane != 2'b00)) || ((size == SZ_H) && lane[0]);
    assign range_err = diff[32] || (|offset[31:ADDR_W+2]);
    assign req       = bus.ena && bus.dm_ena && (state == ST_IDLE) && (is_rd || is_wr);
    assign flt       = misalign || range_err;

    dmem_lane u_lane (
        .word    (bus.mem_rdata),
        .lane    (lane),
        .size    (size),
        .sign    (sign),
        .st_data (bus.dm_data_w[15:0]),
        .ld_data (ld_data),
        .merged  (merged)
    );

    always_comb begin
        next_state = state;
        stall_c    = 1'b0;
        m_en       = 1'b0;
        m_we       = 1'b0;
        m_wdata    = 32'd0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (flt) begin
                        stall_c    = 1'b1;
                        next_state = ST_DONE;
                    end else if (is_rd) begin
                        m_en       = 1'b1;
                        stall_c    = 1'b1;
                        next_state = ST_RD;
                    end else if (size == SZ_W) begin
                        m_en    = 1'b1;
                        m_we    = 1'b1;
                        m_wdata = bus.dm_data_w;
                    end else begin
                        m_en       = 1'b1;
                        stall_c    = 1'b1;
                        next_state = ST_RMW_RD;
                    end
                end
            end
            ST_RD: begin
                stall_c    = 1'b1;
                next_state = ST_DONE;
            end
            ST_RMW_RD: begin
                stall_c    = 1'b1;
                next_state = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                m_en       = 1'b1;
                m_we       = 1'b1;
                m_wdata    = wbuf;
                stall_c    = 1'b1;
                next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // CPU inputs are held stable by stall, so RD/RMW states reuse the live address and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            rdata_q      <= 32'd0;
            wbuf         <= 32'd0;
            flt_pend     <= 1'b0;
            fault_code_q <= FAULT_NONE;
            stall_q      <= 1'b0;
        end else if (bus.ena) begin
            state   <= next_state;
            stall_q <= stall_c;
            if (req && flt) begin
                flt_pend     <= 1'b1;
                fault_code_q <= range_err ? FAULT_RANGE : FAULT_MISALIGN;
                if (is_rd) begin
                    rdata_q <= 32'd0;
                end
            end
            if (state == ST_RD) begin
                rdata_q <= ld_data;
            end
            if (state == ST_RMW_RD) begin
                wbuf <= merged;
            end
            if (state == ST_DONE) begin
                flt_pend <= 1'b0;
            end
        end
    end

    assign bus.mem_en     = bus.ena && m_en;
    assign bus.mem_we     = bus.ena && m_en && m_we;
    assign bus.mem_addr   = (bus.ena && m_en) ? offset[ADDR_W+1:2] : '0;
    assign bus.mem_wdata  = (bus.ena && m_en && m_we) ? m_wdata : 32'd0;
    assign bus.stall      = bus.ena ? stall_c : stall_q;
    assign bus.dm_data    = rdata_q;
    assign bus.fault      = bus.ena && (state == ST_DONE) && flt_pend;
    assign bus.fault_code = fault_code_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Purpose: scoreboard bench for dmem_ctrl with a behavioural sync-read SRAM.
// Latency: checks stall cycle counts per access against hand-computed values.
// Backpressure: driver holds each request until stall drops, then retires it.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    typedef enum int {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW} op_t;

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
        logic        flt;
        logic [1:0]  code;
    } rsp_t;

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [1:0] exp_code;
    logic [31:0] sram [0:2047];
    rsp_t exp_rsp [$];
    wr_t  exp_wr [$];

    dmem_ctrl_if #(.ADDR_W(11)) bus ();

    dmem_ctrl #(.ADDR_W(11), .BASE_ADDR(32'h1001_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync-read single-port SRAM.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                sram[bus.mem_addr] = bus.mem_wdata;
            end else begin
                bus.mem_rdata <= sram[bus.mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: a CPU commit is dm_ena with stall low while enabled.
    always @(negedge clk) begin
        if (!rst && bus.ena && bus.dm_ena && !bus.stall) begin
            if (exp_rsp.size() == 0) begin
                check("unexpected_commit", 32'd1, 32'd0);
            end else begin
                rsp_t r;
                r = exp_rsp.pop_front();
                if (r.chk) check("load_data", bus.dm_data, r.data);
                check("fault_pulse", {31'd0, bus.fault}, {31'd0, r.flt});
                check("fault_code", {30'd0, bus.fault_code}, {30'd0, r.code});
            end
        end
    end

    // Write monitor: every SRAM write must be expected; idle port must be all zero.
    always @(negedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", {21'd0, bus.mem_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                check("wr_addr", {21'd0, bus.mem_addr}, {21'd0, w.addr});
                check("wr_data", bus.mem_wdata, w.data);
            end
        end
        if (!bus.mem_en) begin
            check("mem_idle_zero", {31'd0, (bus.mem_we || bus.mem_addr != 11'd0 || bus.mem_wdata != 32'd0)}, 32'd0);
        end
    end

    task automatic set_req(input op_t op, input logic [31:0] addr, input logic [31:0] wd);
        bus.dm_addr   = addr;
        bus.dm_data_w = wd;
        bus.dm_r      = (op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW});
        bus.dm_w      = (op inside {OP_SB, OP_SH, OP_SW});
        bus.lb_flag   = (op == OP_LB);
        bus.lbu_flag  = (op == OP_LBU);
        bus.lh_flag   = (op == OP_LH);
        bus.lhu_flag  = (op == OP_LHU);
        bus.lw_flag   = (op == OP_LW);
        bus.sb_flag   = (op == OP_SB);
        bus.sh_flag   = (op == OP_SH);
        bus.sw_flag   = (op == OP_SW);
        bus.dm_ena    = 1'b1;
    endtask

    task automatic clr_req();
        bus.dm_ena = 1'b0; bus.dm_r = 1'b0; bus.dm_w = 1'b0;
        bus.dm_addr = 32'd0; bus.dm_data_w = 32'd0;
        bus.lb_flag = 1'b0; bus.lbu_flag = 1'b0; bus.lh_flag = 1'b0;
        bus.lhu_flag = 1'b0; bus.lw_flag = 1'b0;
        bus.sb_flag = 1'b0; bus.sh_flag = 1'b0; bus.sw_flag = 1'b0;
    endtask

    task automatic issue(input op_t op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_data, input logic [1:0] exp_flt,
                         input int exp_stalls, input logic [10:0] wr_addr,
                         input logic [31:0] wr_data, input int hold);
        rsp_t r;
        wr_t  w;
        int   stalls;
        bit   done;
        logic st;
        st = (op inside {OP_SB, OP_SH, OP_SW});
        if (exp_flt != FAULT_NONE) exp_code = exp_flt;
        r.chk  = !st;
        r.data = exp_data;
        r.flt  = (exp_flt != FAULT_NONE);
        r.code = exp_code;
        exp_rsp.push_back(r);
        if (st && exp_flt == FAULT_NONE) begin
            w.addr = wr_addr;
            w.data = wr_data;
            exp_wr.push_back(w);
        end
        set_req(op, addr, wd);
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus.stall) stalls++;
            else done = 1'b1;
            if (c == 0 && hold > 0) begin
                @(posedge clk);
                #1 bus.ena = 1'b0;
                for (int k = 0; k < hold; k++) begin
                    @(negedge clk);
                    check("ena_hold_state", 32'(dut.state), 32'(ST_RD));
                    check("ena_hold_mem_en", {31'd0, bus.mem_en}, 32'd0);
                end
                @(posedge clk);
                #1 bus.ena = 1'b1;
            end
        end
        if (!done) check("stall_timeout", 32'd1, 32'd0);
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        @(posedge clk);
        #1 clr_req();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_code = FAULT_NONE;
        for (int i = 0; i < 2048; i++) sram[i] = 32'd0;
        sram[0] = 32'h8899_AABB;
        sram[2] = 32'hFFFF_FFFF;
        sram[3] = 32'h1122_3344;
        rst     = 1'b1;
        bus.ena = 1'b1;
        clr_req();

        repeat (2) @(negedge clk);
        check("rst_dm_data", bus.dm_data, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        check("rst_fault", {31'd0, bus.fault}, 32'd0);
        check("rst_fault_code", {30'd0, bus.fault_code}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        //     op      address          store data     expected        fault           st  wr  wr data        hold
        issue(OP_LB,  32'h1001_0001, 32'd0,         32'hFFFF_FFAA, FAULT_NONE,     2, 0, 32'd0,         0);
        issue(OP_LBU, 32'h1001_0001, 32'd0,         32'h0000_00AA, FAULT_NONE,     2, 0, 32'd0,         0);
        issue(OP_LB,  32'h1001_0000, 32'd0,         32'hFFFF_FFBB, FAULT_NONE,     2, 0, 32'd0,         0);
        issue(OP_LH,  32'h1001_0002, 32'd0,         32'hFFFF_8899, FAULT_NONE,     2, 0, 32'd0,         0);
        issue(OP_LHU, 32'h1001_0002, 32'd0,         32'h0000_8899, FAULT_NONE,     2, 0, 32'd0,         0);
        issue(OP_SW,  32'h1001_0004, 32'h1234_5678, 32'd0,         FAULT_NONE,     0, 1, 32'h1234_5678, 0);
        issue(OP_LH,  32'h1001_0006, 32'd0,         32'h0000_1234, FAULT_NONE,     2, 0, 32'd0,         0);
        issue(OP_LW,  32'h1001_0000, 32'd0,         32'h8899_AABB, FAULT_NONE,     2, 0, 32'd0,         3);
        issue(OP_SB,  32'h1001_000B, 32'h1234_565A, 32'd0,         FAULT_NONE,     3, 2, 32'h5AFF_FFFF, 0);
        issue(OP_LW,  32'h1001_0008, 32'd0,         32'h5AFF_FFFF, FAULT_NONE,     2, 0, 32'd0,         0);
        issue(OP_SH,  32'h1001_0002, 32'h0000_BEEF, 32'd0,         FAULT_NONE,     3, 0, 32'hBEEF_AABB, 0);
        issue(OP_LW,  32'h1001_0000, 32'd0,         32'hBEEF_AABB, FAULT_NONE,     2, 0, 32'd0,         0);
        issue(OP_SH,  32'h1001_0003, 32'h0000_1111, 32'd0,         FAULT_MISALIGN, 1, 0, 32'd0,         0);
        issue(OP_LW,  32'h0FFF_FFFC, 32'd0,         32'd0,         FAULT_RANGE,    1, 0, 32'd0,         0);
        issue(OP_LW,  32'h1001_2000, 32'd0,         32'd0,         FAULT_RANGE,    1, 0, 32'd0,         0);
        issue(OP_LW,  32'h1001_0002, 32'd0,         32'd0,         FAULT_MISALIGN, 1, 0, 32'd0,         0);
        issue(OP_LHU, 32'h1001_000A, 32'd0,         32'h0000_5AFF, FAULT_NONE,     2, 0, 32'd0,         0);

        // Reset in the middle of an sb read-modify-write: the write must never go out.
        set_req(OP_SB, 32'h1001_000C, 32'h0000_0077);
        @(negedge clk);
        check("rmw_issue_stall", {31'd0, bus.stall}, 32'd1);
        @(posedge clk);
        #1 check("rmw_state_before_rst", 32'(dut.state), 32'(ST_RMW_RD));
        rst = 1'b1;
        clr_req();
        #1;
        check("rst_mid_state", 32'(dut.state), 32'(ST_IDLE));
        check("rst_mid_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_mid_mem_we", {31'd0, bus.mem_we}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_code = FAULT_NONE;
        repeat (4) @(posedge clk);
        check("rmw_word_unchanged", sram[3], 32'h1122_3344);
        #1;
        issue(OP_LB,  32'h1001_000F, 32'd0,         32'h0000_0011, FAULT_NONE,     2, 0, 32'd0,         0);

        repeat (3) @(posedge clk);
        check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
        check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
